// File: rtl/mem_arbiter_6502.sv
// Two-port arbiter sharing one external memory port between the 6502 cache (port 0) and a second master.
// Define MEM_ARB_RR_EN for round-robin on conflicts; otherwise port 0 has fixed priority.
module mem_arbiter_6502 #(
  parameter int BURST_LEN = 8,
  parameter int ADDR_W    = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m0_en,
  input  logic              m1_en,
  input  logic              m0_wr,
  input  logic              m1_wr,
  input  logic              m0_rburst,
  input  logic              m1_rburst,
  input  logic [7:0]        m0_wdata,
  input  logic [7:0]        m1_wdata,
  output logic              m0_rdy,
  output logic              m1_rdy,
  output logic              m0_rdata_load,
  output logic              m1_rdata_load,
  output logic [1:0]        gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_wr,
  output logic              mem_rburst,
  output logic [7:0]        mem_wdata,
  input  logic              mem_rdy,
  input  logic              mem_rdata_load
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [2:0] LAST_BEAT = 3'(BURST_LEN - 1);

  state_t     state, state_nx;
  logic [2:0] beat, beat_nx;
  logic       burst, burst_nx;
  logic       last, last_nx;
  logic       sel;
  logic       owned;
  logic       load_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= 3'd0;
      burst <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nx;
      beat  <= beat_nx;
      burst <= burst_nx;
      last  <= last_nx;
    end
  end

  // The IDLE grant is combinational so a pending request reaches memory with no bubble.
  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    burst_nx = burst;
    last_nx  = last;
    sel      = 1'b0;
    owned    = 1'b0;
    load_ok  = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (m0_en || m1_en)) begin
          owned = 1'b1;
          if (m0_en && m1_en) begin
`ifdef MEM_ARB_RR_EN
            sel = ~last;
`else
            sel = 1'b0;
`endif
          end else begin
            sel = m1_en;
          end
          state_nx = sel ? OWN1 : OWN0;
          burst_nx = sel ? (m1_rburst && !m1_wr) : (m0_rburst && !m0_wr);
          beat_nx  = 3'd0;
        end
      end
      OWN0: begin
        owned   = 1'b1;
        sel     = 1'b0;
        load_ok = 1'b1;
      end
      OWN1: begin
        owned   = 1'b1;
        sel     = 1'b1;
        load_ok = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    // Ownership is released only when the beat count completes, independent of the requester's en.
    if (load_ok && mem_rdata_load) begin
      beat_nx = beat + 3'd1;
      if (!burst || (beat == LAST_BEAT)) begin
        state_nx = IDLE;
        beat_nx  = 3'd0;
        last_nx  = sel;
      end
    end
  end

  assign gnt           = {owned & sel, owned & ~sel};
  assign mem_addr      = sel ? m1_addr  : m0_addr;
  assign mem_wdata     = sel ? m1_wdata : m0_wdata;
  assign mem_en        = owned & (sel ? m1_en     : m0_en);
  assign mem_wr        = owned & (sel ? m1_wr     : m0_wr);
  assign mem_rburst    = owned & (sel ? m1_rburst : m0_rburst);
  assign m0_rdy        = gnt[0] & mem_rdy;
  assign m1_rdy        = gnt[1] & mem_rdy;
  assign m0_rdata_load = load_ok & ~sel & mem_rdata_load;
  assign m1_rdata_load = load_ok &  sel & mem_rdata_load;

endmodule

// File: tb/tb_mem_arbiter_6502.sv
// Scoreboard bench for mem_arbiter_6502: requester and memory models drive traffic, a monitor checks every beat.
`timescale 1ns/1ps
module tb_mem_arbiter_6502;

  localparam int BLEN  = 8;
  localparam int LAT   = 3;
  localparam int LIMIT = 400;

  typedef struct {
    logic [23:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    logic        burst;
    int          drop_after;
  } txn_t;

  typedef struct {
    int          port;
    logic [23:0] addr;
    logic        wr;
    logic [7:0]  wdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] m0_addr, m1_addr;
  logic        m0_en, m1_en, m0_wr, m1_wr, m0_rburst, m1_rburst;
  logic [7:0]  m0_wdata, m1_wdata;
  logic        m0_rdy, m1_rdy, m0_rdata_load, m1_rdata_load;
  logic [1:0]  gnt;
  logic [23:0] mem_addr;
  logic        mem_en, mem_wr, mem_rburst;
  logic [7:0]  mem_wdata;
  logic        mem_load_q, stray_load;
  wire         mem_rdata_load = mem_load_q | stray_load;
  wire         mem_rdy        = mem_load_q | stray_load;

  txn_t q0[$];
  txn_t q1[$];
  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   act0 = 1'b0;
  bit   act1 = 1'b0;
  bit   mem_busy = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_6502 #(.BURST_LEN(BLEN), .ADDR_W(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_en(m0_en), .m1_en(m1_en),
    .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_rburst(m0_rburst), .m1_rburst(m1_rburst),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_rdy(m0_rdy), .m1_rdy(m1_rdy),
    .m0_rdata_load(m0_rdata_load), .m1_rdata_load(m1_rdata_load),
    .gnt(gnt),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_rburst(mem_rburst), .mem_wdata(mem_wdata),
    .mem_rdy(mem_rdy), .mem_rdata_load(mem_rdata_load)
  );

  task automatic checkOutput(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act_v, exp_v);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    n_errors++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  // Queues a transaction for a requester and the beats the monitor should see for it.
  task automatic applyStimulus(input int p, input logic [23:0] a, input logic w, input logic [7:0] d,
                               input logic b, input int drop);
    txn_t t;
    exp_t e;
    int   nb;
    t.addr = a; t.wr = w; t.wdata = d; t.burst = b; t.drop_after = drop;
    if (p == 0) q0.push_back(t);
    else        q1.push_back(t);
    nb = (b && !w) ? BLEN : 1;
    for (int i = 0; i < nb; i++) begin
      e.port = p; e.addr = a; e.wr = w; e.wdata = d;
      sbq.push_back(e);
    end
  endtask

  task automatic drive_req(input int p, input logic en, input logic [23:0] a, input logic w,
                           input logic [7:0] d, input logic b);
    if (p == 0) begin
      m0_en = en; m0_addr = a; m0_wr = w; m0_wdata = d; m0_rburst = b;
    end else begin
      m1_en = en; m1_addr = a; m1_wr = w; m1_wdata = d; m1_rburst = b;
    end
  endtask

  task automatic set_en(input int p, input logic v);
    if (p == 0) m0_en = v;
    else        m1_en = v;
  endtask

  task automatic set_act(input int p, input bit v);
    if (p == 0) act0 = v;
    else        act1 = v;
  endtask

  // Requester model: holds en until granted beats complete, may drop en early in a burst.
  task automatic runPort(input int p);
    txn_t t;
    int   loads = 0;
    int   nb = 1;
    bit   active = 1'b0;
    bit   got;
    drive_req(p, 1'b0, 24'h0, 1'b0, 8'h0, 1'b0);
    forever begin
      @(negedge clk);
      if (active && ((p == 0) ? m0_rdata_load : m1_rdata_load)) loads++;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        active = 1'b0;
        drive_req(p, 1'b0, 24'h0, 1'b0, 8'h0, 1'b0);
      end else begin
        if (active) begin
          if (loads == nb) active = 1'b0;
          else if (loads == t.drop_after) set_en(p, 1'b0);
        end
        if (!active) begin
          got = 1'b0;
          if (p == 0 && q0.size() > 0) begin t = q0.pop_front(); got = 1'b1; end
          else if (p == 1 && q1.size() > 0) begin t = q1.pop_front(); got = 1'b1; end
          if (got) begin
            drive_req(p, 1'b1, t.addr, t.wr, t.wdata, t.burst);
            loads  = 0;
            nb     = (t.burst && !t.wr) ? BLEN : 1;
            active = 1'b1;
          end else begin
            drive_req(p, 1'b0, 24'h0, 1'b0, 8'h0, 1'b0);
          end
        end
      end
      set_act(p, active);
    end
  endtask

  // Memory model: starts on a forwarded request, first beat LAT cycles after the grant cycle.
  task automatic runMemory();
    int beats = 0;
    int waitc = 0;
    mem_load_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && !mem_busy && !mem_load_q && gnt != 2'b00 && mem_en) begin
        mem_busy = 1'b1;
        beats    = (mem_rburst && !mem_wr) ? BLEN : 1;
        waitc    = LAT - 1;
      end
      @(posedge clk);
      #1;
      mem_load_q = 1'b0;
      if (!rst_n) begin
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        if (waitc > 0) begin
          waitc--;
        end else begin
          mem_load_q = 1'b1;
          beats--;
          if (beats == 0) mem_busy = 1'b0;
        end
      end
    end
  endtask

  task automatic runMonitor();
    exp_t e;
    int   port_seen;
    forever begin
      @(negedge clk);
      if (m0_rdata_load || m1_rdata_load) begin
        if (sbq.size() == 0) begin
          failNow("unexpected_load");
        end else begin
          e = sbq.pop_front();
          port_seen = (m0_rdata_load && m1_rdata_load) ? 3 : (m1_rdata_load ? 1 : 0);
          checkOutput("load_port", port_seen, e.port);
          checkOutput("load_gnt", {30'd0, gnt}, (e.port == 1) ? 2 : 1);
          checkOutput("load_rdy", {30'd0, m1_rdy, m0_rdy}, (e.port == 1) ? 2 : 1);
          checkOutput("load_addr", {8'd0, mem_addr}, {8'd0, e.addr});
          checkOutput("load_wr", {31'd0, mem_wr}, {31'd0, e.wr});
          if (e.wr) checkOutput("load_wdata", {24'd0, mem_wdata}, {24'd0, e.wdata});
        end
      end
    end
  endtask

  task automatic waitIdle(input string name);
    int cyc = 0;
    bit done = 1'b0;
    while (!done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      done = (sbq.size() == 0) && !act0 && !act1 && (q0.size() == 0) && (q1.size() == 0) &&
             !mem_busy && !mem_load_q && (gnt == 2'b00);
    end
    if (!done) failNow(name);
  endtask

  // Checks that port p owns the memory at a fixed address every cycle until n of its loads are seen.
  task automatic watchOwner(input string name, input int p, input int n, input logic [23:0] addr);
    int cnt = 0;
    int cyc = 0;
    while (cnt < n && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      checkOutput({name, "_gnt"}, {30'd0, gnt}, (p == 1) ? 2 : 1);
      checkOutput({name, "_addr"}, {8'd0, mem_addr}, {8'd0, addr});
      if ((p == 0) ? m0_rdata_load : m1_rdata_load) cnt++;
    end
    if (cnt < n) failNow({name, "_timeout"});
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_gnt"}, {30'd0, gnt}, 0);
    checkOutput({name, "_mem_ctl"}, {29'd0, mem_en, mem_wr, mem_rburst}, 0);
    checkOutput({name, "_ports"}, {28'd0, m0_rdy, m1_rdy, m0_rdata_load, m1_rdata_load}, 0);
  endtask

  initial begin
    fork
      runPort(0);
      runPort(1);
      runMemory();
      runMonitor();
    join_none
  end

  initial begin
    int cnt;
    int cyc;
    bit pushed;
    stray_load = 1'b0;
    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] conflict from reset, two singles per port");
`ifdef MEM_ARB_RR_EN
    applyStimulus(0, 24'h000100, 1'b0, 8'h00, 1'b0, 1);
    applyStimulus(1, 24'h000200, 1'b0, 8'h00, 1'b0, 1);
    applyStimulus(0, 24'h000101, 1'b0, 8'h00, 1'b0, 1);
    applyStimulus(1, 24'h000201, 1'b0, 8'h00, 1'b0, 1);
`else
    applyStimulus(0, 24'h000100, 1'b0, 8'h00, 1'b0, 1);
    applyStimulus(0, 24'h000101, 1'b0, 8'h00, 1'b0, 1);
    applyStimulus(1, 24'h000200, 1'b0, 8'h00, 1'b0, 1);
    applyStimulus(1, 24'h000201, 1'b0, 8'h00, 1'b0, 1);
`endif
    @(negedge clk);
    checkOutput("conflict_first_gnt", {30'd0, gnt}, 1);
    waitIdle("conflict_idle");

    $display("[TB] single read port 0");
    applyStimulus(0, 24'h00C123, 1'b0, 8'h00, 1'b0, 1);
    @(negedge clk);
    checkOutput("single_gnt0", {30'd0, gnt}, 1);
    checkOutput("single_mem_en", {31'd0, mem_en}, 1);
    checkOutput("single_addr0", {8'd0, mem_addr}, 32'h00C123);
    watchOwner("single", 0, 1, 24'h00C123);
    @(negedge clk);
    checkOutput("single_release", {30'd0, gnt}, 0);
    waitIdle("single_idle");

    $display("[TB] 8-beat burst port 0, en dropped after beat 7");
    applyStimulus(0, 24'h00F000, 1'b0, 8'h00, 1'b1, 7);
    watchOwner("burst", 0, BLEN, 24'h00F000);
    @(negedge clk);
    checkOutput("burst_release", {30'd0, gnt}, 0);
    waitIdle("burst_idle");

    $display("[TB] stray memory load while idle");
    @(posedge clk);
    #1 stray_load = 1'b1;
    @(negedge clk);
    checkOutput("stray_routed", {28'd0, m0_rdy, m1_rdy, m0_rdata_load, m1_rdata_load}, 0);
    @(posedge clk);
    #1 stray_load = 1'b0;
    @(negedge clk);

    $display("[TB] port 1 request during port 0 burst");
    applyStimulus(0, 24'h00E800, 1'b0, 8'h00, 1'b1, 7);
    cnt = 0; cyc = 0; pushed = 1'b0;
    while (cnt < BLEN && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      checkOutput("contend_gnt", {30'd0, gnt}, 1);
      checkOutput("contend_addr", {8'd0, mem_addr}, 32'h00E800);
      if (m0_rdata_load) cnt++;
      if (cnt == 3 && !pushed) begin
        applyStimulus(1, 24'h001234, 1'b0, 8'h00, 1'b0, 1);
        pushed = 1'b1;
      end
    end
    if (cnt < BLEN) failNow("contend_timeout");
    @(negedge clk);
    checkOutput("contend_handover_gnt", {30'd0, gnt}, 2);
    checkOutput("contend_handover_addr", {8'd0, mem_addr}, 32'h001234);
    waitIdle("contend_idle");

    $display("[TB] write then read port 1");
    applyStimulus(1, 24'h002000, 1'b1, 8'hA5, 1'b0, 1);
    applyStimulus(1, 24'h002001, 1'b0, 8'h00, 1'b0, 1);
    @(negedge clk);
    checkOutput("wr_gnt", {30'd0, gnt}, 2);
    checkOutput("wr_mem_wr", {31'd0, mem_wr}, 1);
    checkOutput("wr_wdata", {24'd0, mem_wdata}, 32'hA5);
    watchOwner("wr", 1, 1, 24'h002000);
    @(negedge clk);
    checkOutput("rd_gnt", {30'd0, gnt}, 2);
    checkOutput("rd_addr", {8'd0, mem_addr}, 32'h002001);
    checkOutput("rd_mem_wr", {31'd0, mem_wr}, 0);
    checkOutput("rd_mem_en", {31'd0, mem_en}, 1);
    waitIdle("wr_rd_idle");

    $display("[TB] reset at burst beat 4");
    applyStimulus(0, 24'h003000, 1'b0, 8'h00, 1'b1, 7);
    cnt = 0; cyc = 0;
    while (cnt < 4 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      if (m0_rdata_load) cnt++;
    end
    if (cnt < 4) failNow("rst_beat_timeout");
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    checkResetOutputs("held_reset");
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_gnt", {30'd0, gnt}, 0);
    applyStimulus(1, 24'h004000, 1'b0, 8'h00, 1'b1, BLEN);
    watchOwner("post_reset_burst", 1, BLEN, 24'h004000);
    @(negedge clk);
    checkOutput("post_reset_release", {30'd0, gnt}, 0);
    waitIdle("post_reset_idle");

    checkOutput("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_6502.md
# mem_arbiter_6502

Two-port arbiter that shares the single external memory port between the 6502 cache controller (port 0) and a second bus master (port 1, DMA or video fetch). It sits between the requesters and the memory interface. It forwards one requester's address, control and write data at a time, and routes the per-beat completion strobe back to the owner. It tracks single and 8-beat read-burst transactions so that ownership never changes mid-transaction.

## Interface
Parameters:
- `BURST_LEN`, default 8: beats per `rburst` transaction; must be a power of two, 2..8.
- `ADDR_W`, default 24: memory address width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `m0_addr`, `m1_addr`  in  ADDR_W  requester address.
- `m0_en`, `m1_en`  in  1  request / transaction active.
- `m0_wr`, `m1_wr`  in  1  write when 1.
- `m0_rburst`, `m1_rburst`  in  1  read burst of `BURST_LEN` beats; sampled when the request is granted.
- `m0_wdata`, `m1_wdata`  in  8  write data.
- `m0_rdy`, `m1_rdy`  out  1  `mem_rdy` gated by grant.
- `m0_rdata_load`, `m1_rdata_load`  out  1  `mem_rdata_load` gated by grant.
- `gnt`  out  2  one-hot current owner; 00 when idle.
- `mem_addr`  out  ADDR_W; `mem_en`, `mem_wr`, `mem_rburst`  out  1; `mem_wdata`  out  8: forwarded from the owner.
- `mem_rdy`, `mem_rdata_load`  in  1  from memory. `mem_rdata_load` is the completion strobe for every beat, read or write.

Read data (`mem_rdata0`) is broadcast to both requesters outside this block.

## Operation
- State machine with states IDLE, OWN0, OWN1.
- IDLE: the grant decision is combinational in the same cycle.
  - If one `mN_en` is high, that requester is granted and its signals drive `mem_*` in that cycle. There is no bubble.
  - If both are high, the configured policy decides (see Configuration).
  - The next state is OWNn. `burst` latches `mN_rburst && !mN_wr`. `beat` is cleared.
- OWNn:
  - Forwarding: `mem_addr`/`mem_wr`/`mem_rburst`/`mem_wdata` = requester n; `mem_en` = `mN_en`.
  - Gating: `gnt[n]`=1. `mN_rdy` and `mN_rdata_load` follow memory. The other port sees 0 on both.
  - Each `mem_rdata_load` increments `beat` (3-bit counter).
  - Single transaction ends on the first `mem_rdata_load`.
  - Burst transaction ends on the `BURST_LEN`-th `mem_rdata_load`, i.e. `beat`==`BURST_LEN-1` and load.
  - When a transaction ends, the next state is IDLE and `last` is set to n.
- The requester's `en` may drop before the final burst beat; the cache drops it while waiting for beat 8. The grant is held until the beat count completes, regardless of `en`.
- A request from the other port while OWNn is ignored. It waits until IDLE.
- `mN_en` low in OWNn for a single transaction keeps the grant with `mem_en`=0 until completion.
- Back-to-back: the owner's completion cycle is followed by IDLE.
  - The requester's new `en` in that IDLE cycle is arbitrated immediately.
  - Memory is therefore never idle because of the arbiter when a request is pending.

## Timing
- Reset, asynchronous while `rst_n`=0:
  - `state`=IDLE, `beat`=0, `burst`=0, `last`=1.
  - Outputs: `gnt`=00, `mem_en`=0, `mem_rburst`=0, `mem_wr`=0, `m0/m1_rdy`=0, `m0/m1_rdata_load`=0.
  - `mem_addr` and `mem_wdata` = port 0 values; they are don't-care.
- Reset mid-transaction aborts immediately. Memory must also be reset. No completion strobe is delivered.
- Arbitration latency is 0 cycles from IDLE. A blocked requester waits exactly until the owner's completion cycle, plus the next IDLE cycle.
- `mem_rdata_load` in IDLE is ignored. It is not routed to either port and not counted.
- `beat` wraps 7→0 only at the end of a transaction. It is never observed to wrap inside a transaction.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin.
  - On simultaneous requests in IDLE, grant the port ≠ `last`.
  - First conflict after reset grants port 0.
- `MEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins on conflict. `last` is still maintained but unused.

## Test plan
- Single read, port 0 only:
  - Stimulus: `m0_en`=1, `m0_addr`=0x00C123; memory loads 3 cycles later.
  - Required: `mem_en`=1 and `gnt`=01 the same cycle; `m0_rdata_load` pulses once; IDLE next cycle; `m1_rdata_load` stays 0.
- 8-beat burst, port 0:
  - Stimulus: `m0_rburst`=1, addr 0x00F000; `m0_en` dropped after beat 7.
  - Required: `gnt` holds 01 through all 8 loads; releases the cycle after beat 8.
- Conflict, round-robin (macro defined):
  - Stimulus: both request from reset; each issues 2 singles back-to-back.
  - Required: grant order 0,1,0,1.
  - Same test, macro undefined: order 0,0,1,1.
- Mid-burst contention:
  - Stimulus: `m1_en` rises at port 0 beat 3.
  - Required: port 1 granted only in the IDLE cycle after beat 8; `mem_addr` never switches during the burst.
- Write then read, port 1:
  - Stimulus: `m1_wr`=1, `m1_wdata`=0xA5, then a read.
  - Required: `mem_wdata`=0xA5 with `mem_wr`=1; the write completes on its load; the read is forwarded the next IDLE cycle.
- Reset at burst beat 4:
  - Stimulus: `rst_n` asserted at port 0 burst beat 4.
  - Required: all outputs at reset values asynchronously; after release, a fresh port-1 request is granted with `beat`=0.
